// File: rtl/shift_add_mul_ctrl_pkg.sv
// shift_add_mul_ctrl_pkg: shared state encoding and default operand width
package shift_add_mul_ctrl_pkg;
  localparam int DEF_W = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// shift_add_mul_ctrl_if: operand/product handshake bundle
interface shift_add_mul_ctrl_if
  import shift_add_mul_ctrl_pkg::*;
#(
  parameter int W = DEF_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [2*W-1:0] result;
  logic         busy;
  modport master (
    output in_valid, op_a, op_b, is_signed, out_ready,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  in_valid, op_a, op_b, is_signed, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mul_datapath.sv
// mul_datapath: operand magnitudes, shift-add accumulator, iteration counter and sign fix-up
module mul_datapath
  import shift_add_mul_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           is_signed_i,
  input  logic [W-1:0]   op_a_i,
  input  logic [W-1:0]   op_b_i,
  output logic           last_o,
  output logic [2*W-1:0] prod_o
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] a_q, acc_q;
  logic [W-1:0]   b_q, mag_a, mag_b;
  logic [CW-1:0]  k_q;
  logic           neg_q;
  // negating the most-negative value wraps back to 2^(W-1), which read unsigned is the correct magnitude
  assign mag_a  = (is_signed_i && op_a_i[W-1]) ? -op_a_i : op_a_i;
  assign mag_b  = (is_signed_i && op_b_i[W-1]) ? -op_b_i : op_b_i;
  assign last_o = k_q == CW'(W - 1);
  assign prod_o = neg_q ? -acc_q : acc_q;
  // latch magnitudes on accept, then one conditional shifted add per RUN edge
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      k_q   <= '0;
      neg_q <= 1'b0;
    end else if (load_i) begin
      a_q   <= {{W{1'b0}}, mag_a};
      b_q   <= mag_b;
      acc_q <= '0;
      k_q   <= '0;
      neg_q <= is_signed_i & (op_a_i[W-1] ^ op_b_i[W-1]);
    end else if (step_i) begin
      acc_q <= acc_q + (b_q[k_q] ? (a_q << k_q) : '0);
      k_q   <= k_q + 1'b1;
    end
  end
endmodule

// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: multi-cycle shift-add multiplier with valid/ready handshakes
module shift_add_mul_ctrl
  import shift_add_mul_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input logic clk,
  input logic reset,
  shift_add_mul_ctrl_if.slave bus
);
  state_e         state_q, state_d;
  logic [2*W-1:0] result_q, prod;
  logic           out_valid_q, accept, last;
  assign bus.in_ready  = state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign accept        = bus.in_valid && state_q == IDLE;
  mul_datapath #(.W(W)) u_dp (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .step_i      (state_q == RUN),
    .is_signed_i (bus.is_signed),
    .op_a_i      (bus.op_a),
    .op_b_i      (bus.op_b),
    .last_o      (last),
    .prod_o      (prod)
  );
  // next-state: accept -> W RUN edges -> FIX -> DONE until the product is taken
  always_comb begin
    state_d = state_q == IDLE ? (accept ? RUN : IDLE) :
              state_q == RUN  ? (last ? FIX : RUN) :
              state_q == FIX  ? DONE :
              (bus.out_ready ? IDLE : DONE);
  end
  // state, registered product and out_valid; reset beats any accept or pop on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FIX) begin
        result_q    <= prod;
        out_valid_q <= 1'b1;
      end else if (state_q == DONE && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule
